state_change_logger: RTL and testbench

Downstream consumer of the state monitor. It takes each settled 8-bit input state the monitor reports and stamps it with a coarse time tick. The stamped states are held in a small first-word-fall-through history buffer, so a readout stage can drain the sequence of state changes later. Repeated reports of the same state are suppressed, and the block flags loss when the buffer overflows.

---
 rtl/state_change_logger.sv | 188 ++++++++++++++++++
 tb/tb_state_change_logger.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/state_change_logger.sv
// -----------------------------------------------------------------------------
// state_change_logger
//
// Purpose:
//   Records each settled 8-bit state reported by the state monitor, together
//   with a coarse timestamp, into a small first-word-fall-through history
//   buffer. A readout stage drains the buffer later. A report that repeats the
//   most recently stored state is dropped. A report that finds no space is
//   also dropped, and the sticky overflow flag is set.
//
// Parameters:
//   DEPTH    - number of history entries (power of two, >= 2)
//   TS_WIDTH - timestamp width in ticks
//   TICK_DIV - clk cycles per timestamp tick (>= 1)
//
// Ports:
//   clk        in   1           rising-edge clock
//   reset      in   1           synchronous, active-high reset
//   in_valid   in   1           one-cycle report of a settled state
//   in_state   in   8           settled state word, sampled with in_valid
//   rd_en      in   1           pop the head entry (ignored while empty)
//   clear_ovf  in   1           clear the sticky overflow flag
//   out_valid  out  1           buffer non-empty
//   out_state  out  8           head entry state, 0 when empty
//   out_ts     out  TS_WIDTH    head entry timestamp, 0 when empty
//   count      out  AW+1        entries held, 0..DEPTH
//   full       out  1           count == DEPTH
//   overflow   out  1           sticky, a non-duplicate report was lost
// -----------------------------------------------------------------------------
module state_change_logger #(
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 16,
  parameter int TICK_DIV = 10000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [7:0]                in_state,
  input  logic                      rd_en,
  input  logic                      clear_ovf,
  output logic                      out_valid,
  output logic [7:0]                out_state,
  output logic [TS_WIDTH-1:0]       out_ts,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  // A divide-by-one prescaler still needs a legal one-bit register.
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [CW-1:0]    CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0]    CNT_EMPTY = '0;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0]    pre_q,        pre_d;
  logic [TS_WIDTH-1:0] ts_q,         ts_d;
  logic [AW-1:0]       rd_ptr_q,     rd_ptr_d;
  logic [AW-1:0]       wr_ptr_q,     wr_ptr_d;
  logic [CW-1:0]       count_q,      count_d;
  logic                overflow_q,   overflow_d;
  logic [7:0]          last_state_q, last_state_d;
  logic                last_vld_q,   last_vld_d;

  // History storage is deliberately not reset; the outputs are masked when
  // the buffer is empty, so stale contents are never visible.
  logic [7:0]          state_mem_q [DEPTH];
  logic [TS_WIDTH-1:0] ts_mem_q    [DEPTH];

  // ---------------------------------------------------------------------------
  // Push / pop decisions
  // ---------------------------------------------------------------------------
  logic empty;
  logic is_dup;
  logic want_push;
  logic do_pop;
  logic do_push;
  logic drop;

  always_comb begin
    empty     = (count_q == CNT_EMPTY);
    is_dup    = last_vld_q && (in_state == last_state_q);
    want_push = in_valid && !is_dup;
    do_pop    = rd_en && !empty;
    // A full buffer still accepts a report when the head leaves on the
    // same edge, so the two operations never lose an entry between them.
    do_push   = want_push && ((count_q != CNT_FULL) || do_pop);
    drop      = want_push && !do_push;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pre_d        = pre_q;
    ts_d         = ts_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    last_state_d = last_state_q;
    last_vld_d   = last_vld_q;

    // Prescaler and timestamp; ts wraps silently at its width.
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      ts_d  = ts_q + 1'b1;
    end else begin
      pre_d = pre_q + 1'b1;
    end

    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (do_push) begin
      wr_ptr_d     = wr_ptr_q + 1'b1;
      last_state_d = in_state;
      last_vld_d   = 1'b1;
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A loss in the same cycle outranks the clear request.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q        <= '0;
      ts_q         <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      last_state_q <= '0;
      last_vld_q   <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      ts_q         <= ts_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      last_state_q <= last_state_d;
      last_vld_q   <= last_vld_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage write; the stamp is the ts value before this edge's increment.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      state_mem_q[wr_ptr_q] <= in_state;
      ts_mem_q[wr_ptr_q]    <= ts_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: head entry read combinationally, forced to 0 when empty.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid = !empty;
    out_state = empty ? 8'h00 : state_mem_q[rd_ptr_q];
    out_ts    = empty ? '0 : ts_mem_q[rd_ptr_q];
    count     = count_q;
    full      = (count_q == CNT_FULL);
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_state_change_logger.sv
module tb_state_change_logger;

  localparam int DEPTH = 8;
  localparam int TS_W  = 4;
  localparam int TICK  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [7:0]      in_state;
  logic            rd_en;
  logic            clear_ovf;
  logic            out_valid;
  logic [7:0]      out_state;
  logic [TS_W-1:0] out_ts;
  logic [3:0]      count;
  logic            full;
  logic            overflow;

  state_change_logger #(.DEPTH(DEPTH), .TS_WIDTH(TS_W), .TICK_DIV(TICK)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_state  (in_state),
    .rd_en     (rd_en),
    .clear_ovf (clear_ovf),
    .out_valid (out_valid),
    .out_state (out_state),
    .out_ts    (out_ts),
    .count     (count),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the history is a queue of {state, stamp} pairs; the
  // timestamp is derived from the number of edges since reset.
  typedef struct { int st; int ts; } entry_t;
  entry_t m_q[$];
  int     m_edges;
  int     m_last;
  bit     m_last_vld;
  bit     m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_edges    = 0;
    m_last_vld = 0;
    m_ovf      = 0;
    m_last     = 0;
  endtask

  task automatic model_edge(input bit rst, input bit iv, input int st, input bit rd, input bit clr);
    bit dup, pop, push;
    entry_t e;
    if (rst) begin
      model_reset();
      return;
    end
    dup  = m_last_vld && (st == m_last);
    pop  = rd && (m_q.size() > 0);
    push = iv && !dup && ((m_q.size() < DEPTH) || pop);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      e.st = st;
      e.ts = (m_edges / TICK) % (1 << TS_W);
      m_q.push_back(e);
      m_last     = st;
      m_last_vld = 1;
    end
    if (iv && !dup && !push) m_ovf = 1;
    else if (clr)            m_ovf = 0;
    m_edges++;
  endtask

  task automatic compare_all();
    bit ne;
    ne = m_q.size() > 0;
    chk("out_valid", 32'(out_valid), 32'(ne));
    chk("out_state", 32'(out_state), ne ? 32'(m_q[0].st) : 32'd0);
    chk("out_ts",    32'(out_ts),    ne ? 32'(m_q[0].ts) : 32'd0);
    chk("count",     32'(count),     32'(m_q.size()));
    chk("full",      32'(full),      32'(m_q.size() == DEPTH));
    chk("overflow",  32'(overflow),  32'(m_ovf));
  endtask

  // One clock: drive inputs, advance DUT and model, compare at the negedge.
  task automatic step(input bit rst, input bit iv, input int st, input bit rd, input bit clr);
    reset     = rst;
    in_valid  = iv;
    in_state  = 8'(st);
    rd_en     = rd;
    clear_ovf = clr;
    @(posedge clk);
    model_edge(rst, iv, st, rd, clr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic push(input int st);
    step(0, 1, st, 0, 0);
  endtask

  task automatic pop_expect(input string tag, input int st);
    chk(tag, 32'(out_state), 32'(st));
    step(0, 0, 0, 1, 0);
  endtask

  initial begin
    reset = 1; in_valid = 0; in_state = 0; rd_en = 0; clear_ovf = 0;
    model_reset();
    @(negedge clk);

    // Reset and empty read
    step(1, 0, 0, 0, 0);
    step(1, 1, 8'h44, 0, 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("empty_rd_count", 32'(count), 0);
    chk("empty_rd_state", 32'(out_state), 0);

    // Timestamping: fresh reset, push at edge 9 and edge 70
    step(1, 0, 0, 0, 0);
    idle(9);
    push(8'h11);
    idle(60);
    push(8'h22);
    chk("ts_first_state", 32'(out_state), 32'h11);
    chk("ts_first_stamp", 32'(out_ts), 2);
    step(0, 0, 0, 1, 0);
    chk("ts_second_state", 32'(out_state), 32'h22);
    chk("ts_second_stamp", 32'(out_ts), 1);
    step(0, 0, 0, 1, 0);

    // Duplicate filter
    push(8'h5A); push(8'h5A); push(8'hA5); push(8'h5A);
    chk("dup_count", 32'(count), 3);
    pop_expect("dup_pop0", 8'h5A);
    pop_expect("dup_pop1", 8'hA5);
    pop_expect("dup_pop2", 8'h5A);
    chk("dup_empty", 32'(out_valid), 0);

    // Overflow
    for (int i = 1; i <= 9; i++) push(i);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_flag", 32'(overflow), 1);
    for (int i = 1; i <= 8; i++) pop_expect("ovf_pop", i);
    chk("ovf_drained", 32'(count), 0);
    step(0, 0, 0, 0, 1);
    chk("ovf_cleared", 32'(overflow), 0);

    // Simultaneous push and pop at full
    for (int i = 0; i < 8; i++) push(8'h10 + i);
    chk("sim_full", 32'(full), 1);
    step(0, 1, 8'h77, 1, 0);
    chk("sim_count", 32'(count), 8);
    chk("sim_overflow", 32'(overflow), 0);
    for (int i = 1; i < 8; i++) pop_expect("sim_pop", 8'h10 + i);
    pop_expect("sim_last", 8'h77);
    chk("sim_empty", 32'(count), 0);

    // Reset mid-stream
    push(8'h31); push(8'h32); push(8'h33);
    step(1, 1, 8'h33, 0, 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    push(8'h33);
    chk("midrst_repush_count", 32'(count), 1);
    chk("midrst_repush_state", 32'(out_state), 32'h33);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 6,
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 4,
           $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
